acc_out_stage: RTL and testbench

Parametrised output stage for the bit-serial FIR datapath. It replaces the fixed 32-bit enabled output register and captures the final accumulator sum only after BITS serial bit-cycles of a sample.
- Each captured sum is scaled (arithmetic right shift), then saturated or truncated to OUT_W.
- Results are buffered in a small FWFT FIFO and presented with a valid/ready handshake to the downstream consumer.

---
 rtl/fir_pkg.sv | 35 +++
 rtl/sync_fifo_fwft.sv | 72 +++++++
 rtl/acc_out_stage.sv | 129 ++++++++++++
 tb/tb_acc_out_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and helpers for the bit-serial FIR datapath.
package fir_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } acc_state_t;

    localparam int ACC_W        = 32;
    localparam int BIT_SERIAL_N = 16;
    localparam int SAT_CALC_W   = 64;

    // Clamp a sign-extended value into the signed range of out_w bits (out_w < SAT_CALC_W).
    function automatic logic signed [SAT_CALC_W-1:0] sat_narrow(
        input  logic signed [SAT_CALC_W-1:0] value,
        input  int                           out_w,
        output logic                         clamped
    );
        logic signed [SAT_CALC_W-1:0] max_v;
        logic signed [SAT_CALC_W-1:0] min_v;
        max_v   = (SAT_CALC_W'(1) <<< (out_w - 1)) - SAT_CALC_W'(1);
        min_v   = -max_v - SAT_CALC_W'(1);
        clamped = 1'b0;
        if (value > max_v) begin
            clamped = 1'b1;
            return max_v;
        end
        if (value < min_v) begin
            clamped = 1'b1;
            return min_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; dout shows the head whenever not empty.
module sync_fifo_fwft
    import fir_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 2,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [LVL_W-1:0] level
);

    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == LVL_W'(DEPTH));
    assign level = count_q;
    assign dout  = mem[rd_ptr_q];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the count gates visibility, so stale words are never presented.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/acc_out_stage.sv
// Output stage: captures the accumulator after BITS serial cycles, scales, narrows, buffers.
module acc_out_stage
    import fir_pkg::*;
#(
    parameter int DATA_W     = ACC_W,
    parameter int OUT_W      = 16,
    parameter int SHIFT      = 4,
    parameter int SAT_EN     = 1,
    parameter int BITS       = BIT_SERIAL_N,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              clear,
    input  logic                              start,
    input  logic                              bit_en,
    input  logic [DATA_W-1:0]                 data_in,
    output logic [OUT_W-1:0]                  out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
    output logic                              overflow,
    output logic                              sat_flag,
    output logic                              frame_abort
);

    localparam int              CNT_W    = (BITS > 1) ? $clog2(BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BITS - 1);

    acc_state_t                  state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        overflow_q, overflow_d;
    logic                        sat_q, sat_d;
    logic                        abort_q, abort_d;

    logic                        capture, pop, clamped;
    logic                        fifo_empty, fifo_full;
    logic [OUT_W-1:0]            narrowed, fifo_dout;
    logic signed [DATA_W-1:0]    shifted;
    logic signed [SAT_CALC_W-1:0] shifted_wide;

    always_comb begin
        shifted      = $signed(data_in) >>> SHIFT;
        shifted_wide = SAT_CALC_W'(shifted);
        clamped      = 1'b0;
        if (SAT_EN != 0) narrowed = OUT_W'(sat_narrow(shifted_wide, OUT_W, clamped));
        else             narrowed = OUT_W'(shifted);
    end

    assign capture = (state_q == RUN) && bit_en && (cnt_q == CNT_LAST);
    assign pop     = out_ready && !fifo_empty;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
        sat_d      = sat_q;
        abort_d    = 1'b0;
        if (clear) begin
            state_d    = IDLE;
            cnt_d      = '0;
            overflow_d = 1'b0;
            sat_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
                RUN: begin
                    // A start coinciding with the last bit is a clean back-to-back frame, not an abort.
                    if (capture) begin
                        state_d = start ? RUN : IDLE;
                        cnt_d   = '0;
                    end else if (start) begin
                        cnt_d   = '0;
                        abort_d = 1'b1;
                    end else if (bit_en) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (capture && fifo_full && !pop) overflow_d = 1'b1;
            if (capture && clamped)           sat_d      = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
            sat_q      <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
            sat_q      <= sat_d;
            abort_q    <= abort_d;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push  (capture),
        .din   (narrowed),
        .pop   (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (level)
    );

    assign out_valid   = !fifo_empty;
    assign out_data    = fifo_empty ? '0 : fifo_dout;
    assign busy        = (state_q == RUN);
    assign overflow    = overflow_q;
    assign sat_flag    = sat_q;
    assign frame_abort = abort_q;

endmodule

// File: tb/tb_acc_out_stage.sv
// Self-checking bench for acc_out_stage: directed plan cases plus randomized traffic vs a queue model.
module tb_acc_out_stage;

    localparam int BITS  = 16;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset, clear, start, bit_en, out_ready;
    logic [31:0] data_in;
    logic [15:0] out_data;
    logic        out_valid, busy, overflow, sat_flag, frame_abort;
    logic [1:0]  level;

    always #5 clk = ~clk;

    acc_out_stage #(
        .DATA_W(32), .OUT_W(16), .SHIFT(4), .SAT_EN(1), .BITS(BITS), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear), .start(start), .bit_en(bit_en),
        .data_in(data_in), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .level(level), .overflow(overflow), .sat_flag(sat_flag),
        .frame_abort(frame_abort)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: frame tracker, a queue for the buffer, sticky flags.
    bit m_active;
    int m_nbits;
    int m_q[$];
    bit m_ovf, m_sat, m_abort;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Divide by 16 with floor, then clamp into int16.
    function automatic int model_value(input logic [31:0] d, output bit clamped);
        longint v, s;
        v = longint'($signed(d));
        s = (v >= 0) ? v / 16 : -((-v + 15) / 16);
        clamped = 1'b0;
        if (s > 32767)  begin s = 32767;  clamped = 1'b1; end
        if (s < -32768) begin s = -32768; clamped = 1'b1; end
        return int'(s) & 32'hFFFF;
    endfunction

    task automatic model_reset();
        m_active = 0; m_nbits = 0; m_q.delete();
        m_ovf = 0; m_sat = 0; m_abort = 0;
    endtask

    task automatic model_step();
        bit pop, cap, cl;
        int v;
        if (clear) begin
            model_reset();
            return;
        end
        pop = out_ready && (m_q.size() > 0);
        cap = m_active && bit_en && (m_nbits == BITS - 1);
        m_abort = 0;
        if (pop) void'(m_q.pop_front());
        if (cap) begin
            v = model_value(data_in, cl);
            if (cl) m_sat = 1;
            if (m_q.size() < DEPTH) m_q.push_back(v);
            else m_ovf = 1;
            m_active = start;
            m_nbits  = 0;
        end else if (m_active && start) begin
            m_nbits = 0;
            m_abort = 1;
        end else if (m_active && bit_en) begin
            m_nbits++;
        end else if (!m_active && start) begin
            m_active = 1;
            m_nbits  = 0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"}, out_valid, (m_q.size() > 0));
        check({tag, ".data"},  out_data,  (m_q.size() > 0) ? m_q[0] : 0);
        check({tag, ".level"}, level,     m_q.size());
        check({tag, ".busy"},  busy,      m_active);
        check({tag, ".ovf"},   overflow,  m_ovf);
        check({tag, ".sat"},   sat_flag,  m_sat);
        check({tag, ".abort"}, frame_abort, m_abort);
    endtask

    // Drive one cycle of inputs, advance the model, then compare just after the edge.
    task automatic cyc(input logic st, be, input logic [31:0] d, input logic rdy, clr,
                       input string tag);
        start = st; bit_en = be; data_in = d; out_ready = rdy; clear = clr;
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic frame(input logic [31:0] d, input logic rdy_bits, rdy_last, input string tag);
        cyc(1'b1, 1'b0, 32'h0, rdy_bits, 1'b0, tag);
        for (int i = 0; i < BITS - 1; i++) cyc(1'b0, 1'b1, $urandom, rdy_bits, 1'b0, tag);
        cyc(1'b0, 1'b1, d, rdy_last, 1'b0, tag);
    endtask

    task automatic idle(input logic rdy, input string tag);
        cyc(1'b0, 1'b0, 32'h0, rdy, 1'b0, tag);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".data"},  out_data, 0);
        check({tag, ".valid"}, out_valid, 0);
        check({tag, ".busy"},  busy, 0);
        check({tag, ".level"}, level, 0);
        check({tag, ".ovf"},   overflow, 0);
        check({tag, ".sat"},   sat_flag, 0);
        check({tag, ".abort"}, frame_abort, 0);
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; start = 1'b0; bit_en = 1'b0;
        out_ready = 1'b0; data_in = '0;
        model_reset();
        #1;
        check_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // Basic capture and one-cycle latency
        frame(32'h0001_2340, 1'b0, 1'b0, "basic");
        check("basic.head", out_data, 16'h1234);
        check("basic.sat0", sat_flag, 0);
        idle(1'b1, "basic_pop");

        // Saturation both directions
        frame(32'h0010_0000, 1'b0, 1'b0, "sat_pos");
        check("sat_pos.head", out_data, 16'h7FFF);
        check("sat_pos.flag", sat_flag, 1);
        idle(1'b1, "sat_pop");
        frame(32'hFFF0_0000, 1'b0, 1'b0, "sat_neg");
        check("sat_neg.head", out_data, 16'h8000);

        // Backpressure and overflow
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, "clear");
        check_zero("clear");
        frame(32'h10, 1'b0, 1'b0, "bp");
        frame(32'h20, 1'b0, 1'b0, "bp");
        frame(32'h30, 1'b0, 1'b0, "bp");
        check("bp.level", level, 2);
        check("bp.ovf", overflow, 1);
        check("bp.head1", out_data, 16'h0001);
        idle(1'b1, "bp_pop");
        check("bp.head2", out_data, 16'h0002);
        idle(1'b1, "bp_pop");
        idle(1'b1, "bp_empty_pop");

        // Abort: restart mid-frame needs a full BITS again
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, "clear");
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, "ab");
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 32'h50, 1'b0, 1'b0, "ab");
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, "ab_restart");
        check("ab.pulse", frame_abort, 1);
        cyc(1'b0, 1'b1, 32'h50, 1'b0, 1'b0, "ab");
        check("ab.pulse_end", frame_abort, 0);
        for (int i = 0; i < 14; i++) cyc(1'b0, 1'b1, 32'h50, 1'b0, 1'b0, "ab");
        check("ab.no_cap", level, 0);
        cyc(1'b0, 1'b1, 32'h50, 1'b0, 1'b0, "ab_last");
        check("ab.cap", out_data, 16'h0005);

        // Push and pop together while full
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, "clear");
        frame(32'h100, 1'b0, 1'b0, "sim");
        frame(32'h200, 1'b0, 1'b0, "sim");
        frame(32'h300, 1'b0, 1'b1, "sim");
        check("sim.level", level, 2);
        check("sim.ovf", overflow, 0);
        check("sim.head", out_data, 16'h0020);
        idle(1'b1, "sim_pop");
        check("sim.next", out_data, 16'h0030);

        // Async reset mid-frame with one entry buffered
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, "clear");
        frame(32'h70, 1'b0, 1'b0, "rst");
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, "rst");
        for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 32'h70, 1'b0, 1'b0, "rst");
        check("rst.pre_level", level, 1);
        #2 reset = 1'b1;
        #1;
        check_zero("rst_async");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < BITS; i++) cyc(1'b0, 1'b1, 32'h70, 1'b0, 1'b0, "rst_nostart");
        check("rst.no_cap", level, 0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] d;
            d = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                d = d & 32'h000F_FFFF;
                if ($urandom_range(0, 1) == 0) d = -d;
            end
            cyc($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, d,
                $urandom_range(0, 2) != 0, $urandom_range(0, 299) == 0, "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
